// File: rtl/waveform_uart_tx.sv
// -----------------------------------------------------------------------------
// waveform_uart_tx
//
// Reads DEPTH samples from a synchronous sample RAM. Sends them as one framed
// 8N1 UART packet:
//   0xA5, {pad,ch}, DEPTH[15:8], DEPTH[7:0],
//   then {pad, s[SAMPLE_W-1:8]}, s[7:0] for each sample,
//   then an XOR checksum of every byte after 0xA5.
// Bytes go out back to back with no idle gap.
//
// Ports
//   clk       system clock, all logic on posedge
//   reset_n   asynchronous active-low reset
//   start     1-cycle frame request, honoured only when idle
//   channel   channel to send, latched together with start
//   mem_ch    latched channel, selects the capture RAM
//   mem_addr  sample RAM read address
//   mem_data  RAM read data, one clock behind mem_addr
//   tx        UART line, idles high
//   busy      high from the accepted start to the end of the last stop bit
//   done      1-cycle pulse as busy falls
//   byte_stb  1-cycle pulse each time a byte enters the shift register
// -----------------------------------------------------------------------------
module waveform_uart_tx #(
  parameter int SAMPLE_W     = 14,
  parameter int DEPTH        = 500,
  parameter int NCH          = 4,
  parameter int CLKS_PER_BIT = 434,
  localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CH_W-1:0]     channel,
  output logic [CH_W-1:0]     mem_ch,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [SAMPLE_W-1:0] mem_data,
  output logic                tx,
  output logic                busy,
  output logic                done,
  output logic                byte_stb
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       DEPTH16   = 16'(DEPTH);
  localparam logic [7:0]        SYNC_BYTE = 8'hA5;

  // The state names the kind of byte currently on the line. Sample fetches
  // run in a small pipeline beside the FSM, so there is no separate fetch state.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_SEND_HI = 3'd2;
  localparam logic [2:0] S_SEND_LO = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;

  logic [2:0]          state;
  logic [2:0]          nxt_state;
  logic [7:0]          nxt_byte;
  logic [1:0]          hdr_idx;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [3:0]          bit_cnt;
  logic [8:0]          shreg;
  logic [7:0]          checksum;
  logic [7:0]          cur_lo;
  logic [SAMPLE_W-1:0] sample_reg;
  logic [15:0]         samp_ext;
  logic                last_samp;
  logic [1:0]          fetch_q;
  logic                baud_end;
  logic                byte_end;

  // Zero-extend the sample to 16 bits. When SAMPLE_W <= 8, the high byte is 0x00.
  assign samp_ext = 16'(sample_reg);
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign byte_end = baud_end && (bit_cnt == 4'd9);

  // Pick the byte that follows the one now finishing, and the state that
  // describes it. Only consulted at byte boundaries.
  always_comb begin
    nxt_state = state;
    nxt_byte  = 8'h00;
    case (state)
      S_HDR: begin
        case (hdr_idx)
          2'd0:    nxt_byte = 8'(mem_ch);
          2'd1:    nxt_byte = DEPTH16[15:8];
          2'd2:    nxt_byte = DEPTH16[7:0];
          default: begin
            nxt_byte  = samp_ext[15:8];
            nxt_state = S_SEND_HI;
          end
        endcase
      end
      S_SEND_HI: begin
        nxt_byte  = cur_lo;
        nxt_state = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (last_samp) begin
          nxt_byte  = checksum;
          nxt_state = S_CHK;
        end else begin
          nxt_byte  = samp_ext[15:8];
          nxt_state = S_SEND_HI;
        end
      end
      default: begin
        nxt_state = state;
        nxt_byte  = 8'h00;
      end
    endcase
  end

  // Frame sequencer, bit serializer and sample fetch pipeline.
  // A fetch sets mem_addr and fetch_q[0]. The RAM registers the address on
  // the next edge, and sample_reg captures mem_data one edge later.
  // When a sample's high byte is loaded, its low byte is copied to cur_lo.
  // The fetch for the next sample then starts at once. It finishes long before
  // the low byte has been shifted out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_stb   <= 1'b0;
      mem_addr   <= '0;
      mem_ch     <= '0;
      checksum   <= 8'h00;
      hdr_idx    <= 2'd0;
      baud_cnt   <= '0;
      bit_cnt    <= 4'd0;
      shreg      <= 9'h1FF;
      cur_lo     <= 8'h00;
      sample_reg <= '0;
      last_samp  <= 1'b0;
      fetch_q    <= 2'b00;
    end else begin
      done     <= 1'b0;
      byte_stb <= 1'b0;
      fetch_q  <= {fetch_q[0], 1'b0};
      if (fetch_q[1]) begin
        sample_reg <= mem_data;
      end

      if (state == S_IDLE) begin
        tx <= 1'b1;
        if (start) begin
          // The sync byte is loaded on the accepting edge. Its start bit
          // therefore appears together with busy.
          busy      <= 1'b1;
          mem_ch    <= channel;
          mem_addr  <= '0;
          fetch_q   <= 2'b01;
          checksum  <= 8'h00;
          hdr_idx   <= 2'd0;
          last_samp <= 1'b0;
          tx        <= 1'b0;
          shreg     <= {1'b1, SYNC_BYTE};
          bit_cnt   <= 4'd0;
          baud_cnt  <= '0;
          byte_stb  <= 1'b1;
          state     <= S_HDR;
        end
      end else if (!baud_end) begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end else begin
        baud_cnt <= '0;
        if (!byte_end) begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (state == S_CHK) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          tx    <= 1'b1;
        end else begin
          tx       <= 1'b0;
          shreg    <= {1'b1, nxt_byte};
          bit_cnt  <= 4'd0;
          byte_stb <= 1'b1;
          state    <= nxt_state;
          if (nxt_state != S_CHK) begin
            checksum <= checksum ^ nxt_byte;
          end
          if (state == S_HDR) begin
            hdr_idx <= hdr_idx + 2'd1;
          end
          if (nxt_state == S_SEND_HI) begin
            cur_lo    <= samp_ext[7:0];
            last_samp <= (mem_addr == ADDR_LAST);
            if (mem_addr != ADDR_LAST) begin
              mem_addr   <= mem_addr + ADDR_W'(1);
              fetch_q[0] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_waveform_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_waveform_uart_tx
//
// Three instances of waveform_uart_tx, each with its own parameter set:
//   dut_a  SAMPLE_W=14, DEPTH=2    main frame, back-to-back and reset cases
//   dut_b  SAMPLE_W=8,  DEPTH=1    narrow-sample corner case
//   dut_c  SAMPLE_W=14, DEPTH=300  long frame with random RAM contents
// All three use CLKS_PER_BIT=4. sel chooses which instance is driven and
// watched. Expected frame bytes go into a queue when start is driven. A
// UART decoder pops and compares each byte the line produces.
// -----------------------------------------------------------------------------
module tb_waveform_uart_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  channel;
  logic [1:0]  sel;

  logic        start_a, start_b, start_c;
  logic [1:0]  mem_ch_a, mem_ch_b, mem_ch_c;
  logic [0:0]  addr_a, addr_b;
  logic [8:0]  addr_c;
  logic [13:0] data_a, data_c;
  logic [7:0]  data_b;
  logic        tx_a, tx_b, tx_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        stb_a, stb_b, stb_c;
  logic        m_tx, m_busy, m_done, m_stb;

  logic [13:0] ram_a [0:1];
  logic [7:0]  ram_b [0:1];
  logic [13:0] ram_c [0:511];
  logic [15:0] model_s [0:299];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_byte;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int stb_cnt = 0;
  int bytes_rx = 0;
  int addr_changes = 0;
  int elapsed;
  int cyc;
  int drops;
  int dc0, sc0, br0, ac0;

  always #5 clk = ~clk;

  assign start_a = start & (sel == 2'd0);
  assign start_b = start & (sel == 2'd1);
  assign start_c = start & (sel == 2'd2);
  assign m_tx    = (sel == 2'd0) ? tx_a   : (sel == 2'd1) ? tx_b   : tx_c;
  assign m_busy  = (sel == 2'd0) ? busy_a : (sel == 2'd1) ? busy_b : busy_c;
  assign m_done  = (sel == 2'd0) ? done_a : (sel == 2'd1) ? done_b : done_c;
  assign m_stb   = (sel == 2'd0) ? stb_a  : (sel == 2'd1) ? stb_b  : stb_c;

  waveform_uart_tx #(.SAMPLE_W(14), .DEPTH(2), .NCH(4), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .channel(channel),
    .mem_ch(mem_ch_a), .mem_addr(addr_a), .mem_data(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .byte_stb(stb_a));

  waveform_uart_tx #(.SAMPLE_W(8), .DEPTH(1), .NCH(4), .CLKS_PER_BIT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .channel(channel),
    .mem_ch(mem_ch_b), .mem_addr(addr_b), .mem_data(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .byte_stb(stb_b));

  waveform_uart_tx #(.SAMPLE_W(14), .DEPTH(300), .NCH(4), .CLKS_PER_BIT(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .channel(channel),
    .mem_ch(mem_ch_c), .mem_addr(addr_c), .mem_data(data_c),
    .tx(tx_c), .busy(busy_c), .done(done_c), .byte_stb(stb_c));

  // Synchronous sample RAMs: read data appears one clock after the address.
  always @(posedge clk) begin
    data_a <= ram_a[addr_a];
    data_b <= ram_b[addr_b];
    data_c <= ram_c[addr_c];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Builds the expected frame from model_s and appends it to the scoreboard.
  task automatic pushFrame(input int ch, input int depth, input int sw);
    logic [7:0] b;
    logic [7:0] chk;
    int         s;
    int         mask;
    mask = (1 << sw) - 1;
    exp_q.push_back(8'hA5);
    chk = 8'h00;
    b = 8'(ch);         exp_q.push_back(b); chk = chk ^ b;
    b = 8'(depth >> 8); exp_q.push_back(b); chk = chk ^ b;
    b = 8'(depth);      exp_q.push_back(b); chk = chk ^ b;
    for (int i = 0; i < depth; i++) begin
      s = int'(model_s[i]) & mask;
      b = (sw <= 8) ? 8'h00 : 8'(s >> 8);
      exp_q.push_back(b); chk = chk ^ b;
      b = 8'(s);
      exp_q.push_back(b); chk = chk ^ b;
    end
    exp_q.push_back(chk);
  endtask

  // Queues the expected frame, then pulses start for one clock. On return we
  // are at the negedge right after the accepting edge. The start bit must
  // already be on the line there.
  task automatic applyStimulus(input int ch, input int depth, input int sw);
    pushFrame(ch, depth, sw);
    channel = 2'(ch);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    checkOutput("start_bit_latency", {31'b0, m_tx}, 32'd0);
    checkOutput("busy_rise", {31'b0, m_busy}, 32'd1);
  endtask

  // Start pulse that should be ignored, because the selected instance is busy.
  task automatic pulseIgnored(input int gap);
    repeat (gap) @(negedge clk);
    channel = 2'd3;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    elapsed = elapsed + gap + 1;
  endtask

  task automatic waitDone(input int budget, output int n, output int low_busy);
    n = 0;
    low_busy = 0;
    while (m_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      if (m_done !== 1'b1 && m_busy !== 1'b1) low_busy++;
    end
  endtask

  // Reference UART decoder. It takes 40 samples per byte, one per negedge.
  // Every 4-sample bit cell must be constant. If the scoreboard still holds
  // bytes of the current frame, the next byte must start with no idle cycle.
  initial begin
    logic [39:0] bits;
    logic [7:0]  d;
    logic [8:0]  e;
    int          n;
    int          bad;
    bit          gap;
    n = 0;
    gap = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        n = 0;
        gap = 1'b0;
      end else if (n == 0) begin
        if (gap) begin
          checkOutput("no_gap", {31'b0, m_tx}, 32'd0);
          gap = 1'b0;
        end
        if (m_tx === 1'b0) begin
          bits[0] = 1'b0;
          n = 1;
        end
      end else begin
        bits[n] = m_tx;
        n++;
        if (n == 40) begin
          n = 0;
          bad = 0;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < 4; k++)
              if (bits[4*b+k] !== bits[4*b]) bad++;
          for (int k = 0; k < 8; k++) d[k] = bits[4*(k+1)+2];
          checkOutput("bit_timing", 32'(bad), 32'd0);
          checkOutput("stop_bit", {31'b0, bits[36]}, 32'd1);
          e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
          checkOutput("frame_byte", {23'b0, 1'b0, d}, {23'b0, e});
          last_byte = d;
          bytes_rx++;
          gap = (exp_q.size() > 0);
        end
      end
    end
  end

  // Counts done and byte_stb pulses, and follows the read address of the
  // long-frame instance.
  initial begin
    logic [8:0] a_last;
    a_last = 9'd0;
    forever begin
      @(negedge clk);
      if (m_done === 1'b1) done_cnt++;
      if (m_stb === 1'b1) stb_cnt++;
      if (reset_n !== 1'b1) begin
        a_last = 9'd0;
      end else if (sel == 2'd2 && addr_c !== a_last) begin
        checkOutput("addr_step", 32'(addr_c), 32'(a_last) + 32'd1);
        a_last = addr_c;
        addr_changes++;
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    channel = 2'd0;
    sel     = 2'd0;
    ram_a[0] = 14'h1234;
    ram_a[1] = 14'h0ABC;
    ram_b[0] = 8'hFF;
    ram_b[1] = 8'h00;
    for (int i = 0; i < 512; i++) ram_c[i] = 14'h0;
    $display("[TB] start");

    repeat (3) @(negedge clk);
    checkOutput("rst_tx", {29'b0, tx_a, tx_b, tx_c}, 32'h7);
    checkOutput("rst_busy", {29'b0, busy_a, busy_b, busy_c}, 32'h0);
    checkOutput("rst_done", {29'b0, done_a, done_b, done_c}, 32'h0);
    checkOutput("rst_stb", {29'b0, stb_a, stb_b, stb_c}, 32'h0);
    checkOutput("rst_addr", {21'b0, addr_a, addr_b, addr_c}, 32'h0);
    checkOutput("rst_mem_ch", {26'b0, mem_ch_a, mem_ch_b, mem_ch_c}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Frame on channel 1, samples 0x1234/0x0ABC.
    // Checksum = 01^00^02^12^34^0A^BC = 0x93.
    $display("[TB] basic frame");
    model_s[0] = 16'h1234;
    model_s[1] = 16'h0ABC;
    dc0 = done_cnt; sc0 = stb_cnt; br0 = bytes_rx;
    applyStimulus(1, 2, 14);
    checkOutput("mem_ch_latch", 32'(mem_ch_a), 32'd1);
    waitDone(1000, cyc, drops);
    checkOutput("frame1_busy_clks", 32'(cyc), 32'd360);
    checkOutput("frame1_busy_hold", 32'(drops), 32'd0);
    checkOutput("frame1_end_busy", {31'b0, m_busy}, 32'd0);
    checkOutput("frame1_end_tx", {31'b0, m_tx}, 32'd1);
    @(negedge clk);
    checkOutput("done_width", {31'b0, m_done}, 32'd0);
    checkOutput("frame1_done_cnt", 32'(done_cnt - dc0), 32'd1);
    checkOutput("frame1_stb_cnt", 32'(stb_cnt - sc0), 32'd9);
    checkOutput("frame1_bytes", 32'(bytes_rx - br0), 32'd9);
    checkOutput("frame1_queue", 32'(exp_q.size()), 32'd0);
    checkOutput("frame1_chk", 32'(last_byte), 32'h93);
    checkOutput("frame1_addr_hold", 32'(addr_a), 32'd1);

    // Start pulses while busy are ignored. A start during the done cycle is
    // accepted at once.
    $display("[TB] ignored starts and back-to-back frame");
    dc0 = done_cnt; br0 = bytes_rx;
    applyStimulus(0, 2, 14);
    elapsed = 0;
    pulseIgnored(20);
    pulseIgnored(100);
    pulseIgnored(150);
    checkOutput("mem_ch_while_busy", 32'(mem_ch_a), 32'd0);
    waitDone(1000, cyc, drops);
    checkOutput("frame2_busy_clks", 32'(cyc + elapsed), 32'd360);
    checkOutput("frame2_done", {31'b0, m_done}, 32'd1);
    applyStimulus(2, 2, 14);
    checkOutput("b2b_mem_ch", 32'(mem_ch_a), 32'd2);
    waitDone(1000, cyc, drops);
    checkOutput("frame3_busy_clks", 32'(cyc), 32'd360);
    checkOutput("frame3_busy_hold", 32'(drops), 32'd0);
    @(negedge clk);
    checkOutput("frame23_done_cnt", 32'(done_cnt - dc0), 32'd2);
    checkOutput("frame23_bytes", 32'(bytes_rx - br0), 32'd18);
    checkOutput("frame23_queue", 32'(exp_q.size()), 32'd0);

    // Reset partway through the fifth byte, then send a clean frame.
    $display("[TB] reset mid-frame");
    dc0 = done_cnt; br0 = bytes_rx;
    applyStimulus(3, 2, 14);
    repeat (180) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abort_tx", {31'b0, tx_a}, 32'd1);
    checkOutput("abort_busy", {31'b0, busy_a}, 32'd0);
    checkOutput("abort_addr", 32'(addr_a), 32'd0);
    checkOutput("abort_mem_ch", 32'(mem_ch_a), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    applyStimulus(1, 2, 14);
    waitDone(1000, cyc, drops);
    checkOutput("frame4_busy_clks", 32'(cyc), 32'd360);
    @(negedge clk);
    checkOutput("frame4_bytes", 32'(bytes_rx - br0), 32'd13);
    checkOutput("frame4_queue", 32'(exp_q.size()), 32'd0);
    checkOutput("frame4_chk", 32'(last_byte), 32'h93);

    // 8-bit samples, one sample of 0xFF: A5 00 00 01 00 FF FE.
    $display("[TB] narrow samples");
    sel = 2'd1;
    @(negedge clk);
    model_s[0] = 16'h00FF;
    dc0 = done_cnt; br0 = bytes_rx; sc0 = stb_cnt;
    applyStimulus(0, 1, 8);
    waitDone(1000, cyc, drops);
    checkOutput("frame5_busy_clks", 32'(cyc), 32'd280);
    @(negedge clk);
    checkOutput("frame5_bytes", 32'(bytes_rx - br0), 32'd7);
    checkOutput("frame5_stb_cnt", 32'(stb_cnt - sc0), 32'd7);
    checkOutput("frame5_chk", 32'(last_byte), 32'hFE);
    checkOutput("frame5_addr", 32'(addr_b), 32'd0);
    checkOutput("frame5_mem_ch", 32'(mem_ch_b), 32'd0);

    // 300 random samples: every address exactly once, in order, no wrap.
    $display("[TB] long frame");
    sel = 2'd2;
    for (int i = 0; i < 300; i++) begin
      ram_c[i]   = 14'($urandom_range(0, 16383));
      model_s[i] = 16'(ram_c[i]);
    end
    @(negedge clk);
    dc0 = done_cnt; br0 = bytes_rx; ac0 = addr_changes;
    applyStimulus(2, 300, 14);
    waitDone(30000, cyc, drops);
    checkOutput("frame6_busy_clks", 32'(cyc), 32'd24200);
    checkOutput("frame6_busy_hold", 32'(drops), 32'd0);
    @(negedge clk);
    checkOutput("frame6_bytes", 32'(bytes_rx - br0), 32'd605);
    checkOutput("frame6_addr_steps", 32'(addr_changes - ac0), 32'd299);
    checkOutput("frame6_addr_hold", 32'(addr_c), 32'd299);
    checkOutput("frame6_mem_ch", 32'(mem_ch_c), 32'd2);
    checkOutput("frame6_done_cnt", 32'(done_cnt - dc0), 32'd1);
    checkOutput("frame6_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
